// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and types for the 640x480 VGA sync monitor:
//   - default line/frame totals, sync pulse widths and active windows
//   - position and measurement widths
//   - monitor lock FSM state encoding
//   - saturating position increment helper
// ---------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int POS_W  = 10;   // h_pos / v_pos / pulse width
   localparam int MEAS_W = 11;   // measured line length / frame height
   localparam int CNT_W  = 4;    // good-frame counter

   localparam int VGA_H_TOTAL     = 800;
   localparam int VGA_V_TOTAL     = 525;
   localparam int VGA_H_PULSE     = 96;
   localparam int VGA_V_PULSE     = 2;
   localparam int VGA_H_ACT_START = 144;
   localparam int VGA_H_ACT_LEN   = 640;
   localparam int VGA_V_ACT_START = 35;
   localparam int VGA_V_ACT_LEN   = 480;
   localparam int VGA_LOCK_FRAMES = 2;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } mon_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] val);
      return (&val) ? val : val + POS_W'(1);
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// ---------------------------------------------------------------------------
// vga_sync_edge
// Brings one raw sync line into the clk domain (two flops) and keeps one more
// delayed copy so falling/rising edges can be flagged for a single cycle.
// All flops reset high, matching the idle level of an active-low sync.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_async    raw sync input
//   o_level    synchronised level
//   o_fall     1-cycle pulse on a synchronised high->low transition
//   o_rise     1-cycle pulse on a synchronised low->high transition
// ---------------------------------------------------------------------------
module vga_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_level,
   output logic o_fall,
   output logic o_rise
);

   logic r_s1;
   logic r_s2;
   logic r_dly;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1  <= 1'b1;
         r_s2  <= 1'b1;
         r_dly <= 1'b1;
      end else begin
         r_s1  <= i_async;
         r_s2  <= r_s1;
         r_dly <= r_s2;
      end
   end

   assign o_level = r_s2;
   assign o_fall  = r_dly & ~r_s2;
   assign o_rise  = ~r_dly & r_s2;

endmodule

// File: rtl/vga_sync_monitor.sv
// ---------------------------------------------------------------------------
// vga_sync_monitor
// Receive-side VGA timing monitor. Synchronises raw hsync/vsync, measures line
// length and frame height, locks after LOCK_FRAMES consecutive good frames and
// rebuilds pixel/line positions plus an active-video flag while locked.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   hsync_in, vsync_in       raw active-low sync inputs
//   h_pos, v_pos             reconstructed position, saturating at 1023
//   h_period, v_lines        last measured line length / frame height
//   h_pulse_width            last measured hsync low width (0 without checks)
//   line_start, frame_start  1-cycle pulses on h_pos / v_pos reload
//   video_active             locked and inside the active window
//   locked                   lock status
//   sync_err                 sticky lock-loss flag, cleared only by rst
// Build option: define VGA_SYNC_MON_PULSE_CHECK_EN to also measure the hsync
// and vsync low widths and require them to match before/while locked.
// ---------------------------------------------------------------------------
module vga_sync_monitor
   import vga_timing_pkg::*;
#(
   parameter int EXP_H_TOTAL = VGA_H_TOTAL,
   parameter int EXP_V_TOTAL = VGA_V_TOTAL,
   parameter int EXP_H_PULSE = VGA_H_PULSE,
   parameter int EXP_V_PULSE = VGA_V_PULSE,
   parameter int H_ACT_START = VGA_H_ACT_START,
   parameter int H_ACT_LEN   = VGA_H_ACT_LEN,
   parameter int V_ACT_START = VGA_V_ACT_START,
   parameter int V_ACT_LEN   = VGA_V_ACT_LEN,
   parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hsync_in,
   input  logic              vsync_in,
   output logic [POS_W-1:0]  h_pos,
   output logic [POS_W-1:0]  v_pos,
   output logic [MEAS_W-1:0] h_period,
   output logic [MEAS_W-1:0] v_lines,
   output logic [POS_W-1:0]  h_pulse_width,
   output logic              line_start,
   output logic              frame_start,
   output logic              video_active,
   output logic              locked,
   output logic              sync_err
);

   localparam logic [POS_W-1:0] H_SAT_M1 = {{(POS_W-1){1'b1}}, 1'b0};

   logic w_hs_lvl, w_hs_fall, w_hs_rise;
   logic w_vs_lvl, w_vs_fall, w_vs_rise;

   vga_sync_edge u_hs_edge (
      .clk(clk), .rst(rst), .i_async(hsync_in),
      .o_level(w_hs_lvl), .o_fall(w_hs_fall), .o_rise(w_hs_rise)
   );

   vga_sync_edge u_vs_edge (
      .clk(clk), .rst(rst), .i_async(vsync_in),
      .o_level(w_vs_lvl), .o_fall(w_vs_fall), .o_rise(w_vs_rise)
   );

   logic [POS_W-1:0]  r_h_pos, r_v_pos;
   logic [MEAS_W-1:0] r_h_period, r_v_lines;
   logic              r_vs_pend, r_line_start, r_frame_start;
   mon_state_e        r_state;
   logic              r_frame_ok, r_locked, r_sync_err;
   logic [CNT_W-1:0]  r_good_cnt;

   logic [MEAS_W-1:0] w_h_next, w_v_next;
   logic              w_frame_go, w_pulse_bad, w_line_bad, w_v_ok, w_h_sat;
   logic              w_h_in, w_v_in;

   assign w_h_next = {1'b0, r_h_pos} + MEAS_W'(1);
   assign w_v_next = {1'b0, r_v_pos} + MEAS_W'(1);

   // A pending vsync edge (or one arriving together with hsync) closes the
   // frame on the next hsync fall.
   assign w_frame_go = w_hs_fall & (r_vs_pend | w_vs_fall);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h_pos       <= '0;
         r_v_pos       <= '0;
         r_h_period    <= '0;
         r_v_lines     <= '0;
         r_vs_pend     <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_line_start  <= w_hs_fall;
         r_frame_start <= w_frame_go;
         if (w_hs_fall) begin
            r_h_pos    <= '0;
            r_h_period <= w_h_next;
            if (w_frame_go) begin
               r_v_pos   <= '0;
               r_v_lines <= w_v_next;
            end else begin
               r_v_pos <= sat_inc(r_v_pos);
            end
         end else begin
            r_h_pos <= sat_inc(r_h_pos);
         end
         if (w_frame_go)
            r_vs_pend <= 1'b0;
         else if (w_vs_fall)
            r_vs_pend <= 1'b1;
      end
   end

`ifdef VGA_SYNC_MON_PULSE_CHECK_EN
   logic [POS_W-1:0] r_h_pw;
   logic [POS_W-1:0] r_vs_cnt;
   logic [POS_W-1:0] w_h_pw_new;
   logic             w_unused_sync;

   assign w_h_pw_new = sat_inc(r_h_pos);

   // vsync width is counted in hsync falls seen while vsync is low; a fall
   // coinciding with the vsync fall is the first line of the pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h_pw   <= '0;
         r_vs_cnt <= '0;
      end else begin
         if (w_hs_rise)
            r_h_pw <= w_h_pw_new;
         if (w_vs_fall)
            r_vs_cnt <= {{(POS_W-1){1'b0}}, w_hs_fall};
         else if (w_hs_fall & ~w_vs_lvl)
            r_vs_cnt <= sat_inc(r_vs_cnt);
      end
   end

   assign w_pulse_bad = (w_hs_rise & (w_h_pw_new != POS_W'(EXP_H_PULSE))) |
                        (w_vs_rise & (r_vs_cnt != POS_W'(EXP_V_PULSE)));
   assign h_pulse_width = r_h_pw;
   assign w_unused_sync = w_hs_lvl;
`else
   logic w_unused_sync;
   assign w_pulse_bad   = 1'b0;
   assign h_pulse_width = '0;
   // Edge/level outputs only consumed when pulse checking is built in.
   assign w_unused_sync = ^{w_hs_lvl, w_hs_rise, w_vs_lvl, w_vs_rise};
`endif

   assign w_line_bad = (w_hs_fall & (w_h_next != MEAS_W'(EXP_H_TOTAL))) | w_pulse_bad;
   assign w_v_ok     = (w_v_next == MEAS_W'(EXP_V_TOTAL));
   // Next edge would saturate h_pos: hsync has effectively disappeared.
   assign w_h_sat    = ~w_hs_fall & (r_h_pos == H_SAT_M1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_SEARCH;
         r_frame_ok <= 1'b0;
         r_good_cnt <= '0;
         r_locked   <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         case (r_state)
            ST_SEARCH: begin
               if (w_frame_go) begin
                  r_state    <= ST_MEASURE;
                  r_frame_ok <= 1'b1;
                  r_good_cnt <= '0;
               end
            end
            ST_MEASURE: begin
               if (w_frame_go) begin
                  r_frame_ok <= 1'b1;
                  // closing line and frame height folded in at this edge
                  if (r_frame_ok & ~w_line_bad & w_v_ok) begin
                     r_good_cnt <= r_good_cnt + CNT_W'(1);
                     if ((r_good_cnt + CNT_W'(1)) >= CNT_W'(LOCK_FRAMES)) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                     end
                  end else begin
                     r_good_cnt <= '0;
                  end
               end else if (w_line_bad) begin
                  r_frame_ok <= 1'b0;
               end
            end
            ST_LOCKED: begin
               if (w_line_bad | (w_frame_go & ~w_v_ok) | w_h_sat) begin
                  r_state    <= ST_SEARCH;
                  r_locked   <= 1'b0;
                  r_sync_err <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_SEARCH;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   assign w_h_in = (r_h_pos >= POS_W'(H_ACT_START)) &&
                   ({1'b0, r_h_pos} < MEAS_W'(H_ACT_START + H_ACT_LEN));
   assign w_v_in = (r_v_pos >= POS_W'(V_ACT_START)) &&
                   ({1'b0, r_v_pos} < MEAS_W'(V_ACT_START + V_ACT_LEN));

   assign h_pos        = r_h_pos;
   assign v_pos        = r_v_pos;
   assign h_period     = r_h_period;
   assign v_lines      = r_v_lines;
   assign line_start   = r_line_start;
   assign frame_start  = r_frame_start;
   assign locked       = r_locked;
   assign sync_err     = r_sync_err;
   assign video_active = r_locked & w_h_in & w_v_in;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_monitor
// Bench for vga_sync_monitor using a scaled-down timing (40 clocks x 12 lines)
// so several frames fit in a short run. A stimulus generator drives
// hsync/vsync from its own h/v counters; every driven count is queued and
// compared against h_pos/v_pos three cycles later. Frame-level scenarios come
// from a vector table; lock, error and saturation corners are hand sequences.
// ---------------------------------------------------------------------------
module tb_vga_sync_monitor;

   localparam int H   = 40;
   localparam int V   = 12;
   localparam int HP  = 6;
   localparam int VP  = 2;
   localparam int HAS = 10;
   localparam int HAL = 20;
   localparam int VAS = 3;
   localparam int VAL = 6;
`ifdef VGA_SYNC_MON_PULSE_CHECK_EN
   localparam bit PCHK = 1'b1;
`else
   localparam bit PCHK = 1'b0;
`endif
   localparam int PW6 = PCHK ? HP : 0;

   logic        clk, rst, hsync_in, vsync_in;
   logic [9:0]  h_pos, v_pos, h_pulse_width;
   logic [10:0] h_period, v_lines;
   logic        line_start, frame_start, video_active, locked, sync_err;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_va  = 1'b0;

   typedef struct {
      int h;
      int v;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      int h_tot;
      int v_tot;
      int hpw;
      int nfr;
      bit e_lock;
      int e_hper;
      int e_vl;
      int e_hpw;
   } vec_t;
   vec_t vecs[5];

   vga_sync_monitor #(
      .EXP_H_TOTAL(H), .EXP_V_TOTAL(V), .EXP_H_PULSE(HP), .EXP_V_PULSE(VP),
      .H_ACT_START(HAS), .H_ACT_LEN(HAL), .V_ACT_START(VAS), .V_ACT_LEN(VAL),
      .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .h_pos(h_pos), .v_pos(v_pos), .h_period(h_period), .v_lines(v_lines),
      .h_pulse_width(h_pulse_width), .line_start(line_start),
      .frame_start(frame_start), .video_active(video_active),
      .locked(locked), .sync_err(sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] in_win(input int h, input int v);
      return (h >= HAS && h < HAS + HAL && v >= VAS && v < VAS + VAL) ? 32'd1 : 32'd0;
   endfunction

   // One generator cycle: compare the count driven three cycles ago, then
   // drive this cycle's sync levels and queue the count.
   task automatic step(input int h, input int v, input int hpw, output int eh);
      sb_t e;
      @(negedge clk);
      eh = -1;
      if (sb.size() >= 3) begin
         e  = sb.pop_front();
         eh = e.h;
         check("h_pos", 32'(h_pos), e.h);
         check("v_pos", 32'(v_pos), e.v);
         if (chk_va)
            check("video_active", 32'(video_active), in_win(e.h, e.v));
      end
      hsync_in = (h >= hpw);
      vsync_in = (v >= VP);
      e.h = h;
      e.v = v;
      sb.push_back(e);
   endtask

   task automatic run_line(input int len, input int hpw, input int v, input int c0);
      int eh;
      for (int c = c0; c < len; c++)
         step(c, v, hpw, eh);
   endtask

   task automatic run_frame(input int htot, input int vtot, input int hpw);
      for (int v = 0; v < vtot; v++)
         run_line(htot, hpw, v, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      #1;
      check("rst_h_pos", 32'(h_pos), 0);
      check("rst_v_pos", 32'(v_pos), 0);
      check("rst_h_period", 32'(h_period), 0);
      check("rst_v_lines", 32'(v_lines), 0);
      check("rst_h_pulse_width", 32'(h_pulse_width), 0);
      check("rst_flags", 32'({line_start, frame_start, video_active, locked, sync_err}), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
   endtask

   // Two clean frames, then the third frame_start must bring lock.
   task automatic lock_up();
      int eh;
      run_frame(H, V, HP);
      run_frame(H, V, HP);
      check("pre_lock", 32'(locked), 0);
      for (int c = 0; c < 4; c++)
         step(c, 0, HP, eh);
      check("lock_3rd_fs", 32'(locked), 1);
      check("lock_fs_pulse", 32'(frame_start), 1);
      run_line(H, HP, 0, 4);
   endtask

   initial begin
      int eh;
      int prev;
      rst      = 1'b1;
      hsync_in = 1'b1;
      vsync_in = 1'b1;

      vecs[0] = '{H,     V,     HP,     1, 1'b0,  H,     V,     PW6};
      vecs[1] = '{H,     V,     HP,     2, 1'b1,  H,     V,     PW6};
      vecs[2] = '{H,     V,     HP - 1, 3, ~PCHK, H,     V,     PCHK ? HP - 1 : 0};
      vecs[3] = '{H,     V + 1, HP,     3, 1'b0,  H,     V + 1, PW6};
      vecs[4] = '{H + 1, V,     HP,     3, 1'b0,  H + 1, V,     PW6};

      for (int i = 0; i < 5; i++) begin
         do_reset();
         for (int f = 0; f < vecs[i].nfr; f++)
            run_frame(vecs[i].h_tot, vecs[i].v_tot, vecs[i].hpw);
         run_line(vecs[i].h_tot, vecs[i].hpw, 0, 0);
         check($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].e_lock));
         check($sformatf("vec%0d_h_period", i), 32'(h_period), vecs[i].e_hper);
         check($sformatf("vec%0d_v_lines", i), 32'(v_lines), vecs[i].e_vl);
         check($sformatf("vec%0d_h_pulse_width", i), 32'(h_pulse_width), vecs[i].e_hpw);
         check($sformatf("vec%0d_sync_err", i), 32'(sync_err), 0);
      end

      // Locked frame with window checks, coincident h/v fall, then a long line.
      do_reset();
      lock_up();
      chk_va = 1'b1;
      for (int v = 1; v < V; v++)
         run_line(H, HP, v, 0);
      chk_va = 1'b0;
      for (int c = 0; c < 4; c++)
         step(c, 0, HP, eh);
      check("coinc_line_start", 32'(line_start), 1);
      check("coinc_frame_start", 32'(frame_start), 1);
      check("coinc_v_pos", 32'(v_pos), 0);
      check("coinc_v_lines", 32'(v_lines), V);
      check("coinc_h_period", 32'(h_period), H);
      check("coinc_locked", 32'(locked), 1);
      run_line(H, HP, 0, 4);
      run_line(H + 1, HP, 1, 0);
      for (int c = 0; c < 3; c++)
         step(c, 2, HP, eh);
      check("long_line_pre", 32'(locked), 1);
      step(3, 2, HP, eh);
      check("long_line_unlock", 32'(locked), 0);
      check("long_line_sync_err", 32'(sync_err), 1);
      check("long_line_h_period", 32'(h_period), H + 1);
      check("long_line_line_start", 32'(line_start), 1);
      run_line(H, HP, 2, 4);
      run_line(H, HP, 3, 0);
      check("sync_err_sticky", 32'(sync_err), 1);

      // hsync stuck high while locked: h_pos saturates and lock drops.
      do_reset();
      lock_up();
      prev = -1;
      for (int c = 0; c < 1040; c++) begin
         step((c > 1023) ? 1023 : c, 1, HP, eh);
         if (eh == 1022)
            check("sat_locked_before", 32'(locked), 1);
         if (eh == 1023 && prev == 1022) begin
            check("sat_unlock", 32'(locked), 0);
            check("sat_sync_err", 32'(sync_err), 1);
         end
         prev = eh;
      end
      check("sat_h_pos_final", 32'(h_pos), 1023);

      // Reset in the middle of a line while locked, then relock.
      do_reset();
      lock_up();
      run_line(H / 2, HP, 1, 0);
      do_reset();
      lock_up();
      check("relock_sync_err", 32'(sync_err), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
